tile_scroll_ctrl: RTL and testbench

Sequencing controller for the tile-scroll offset counter in the piano-tiles game. It owns the game state, generates the `offset_increase` scroll pulses from a programmable rate divider and issues `edge_go` when a row has fully scrolled. It also scores key presses, tracks lives and speeds up scrolling as rows pass. It sits between the keyboard/hit-detect logic and the offset counter, and drives the counter's `current_state` input.

---
 rtl/tile_scroll_ctrl.sv | 154 +++++++++++++++
 tb/tb_tile_scroll_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scroll_ctrl.sv
// Game sequencer for the piano-tiles scroll path: paces offset_increase from a
// shrinking rate divider, issues edge_go per completed row, and tracks score and lives.
module tile_scroll_ctrl #(
  parameter int unsigned TICK_DIV     = 833333,
  parameter int unsigned MIN_DIV      = 208333,
  parameter int unsigned DIV_STEP     = 41667,
  parameter int unsigned ROW_HEIGHT   = 40,
  parameter int unsigned SPEEDUP_ROWS = 8,
  parameter int unsigned LIVES        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] offset,
  input  logic       key_hit,
  input  logic       key_miss,
  output logic [5:0] current_state,
  output logic       offset_increase,
  output logic       edge_go,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
  localparam int unsigned ROW_W = (SPEEDUP_ROWS < 2) ? 1 : $clog2(SPEEDUP_ROWS + 1);

  localparam logic [DIV_W-1:0] TICK_DIV_V = DIV_W'(TICK_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV_V  = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DIV_STEP_V = DIV_W'(DIV_STEP);
  localparam logic [ROW_W-1:0] SPEEDUP_V  = ROW_W'(SPEEDUP_ROWS);
  localparam logic [5:0]       EDGE_AT    = 6'(ROW_HEIGHT - 1);
  localparam logic [2:0]       LIVES_V    = 3'(LIVES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SHIFT = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_W-1:0] period, period_nxt;
  logic [ROW_W-1:0] row_cnt, row_cnt_nxt;
  logic             hit_flag, hit_flag_nxt;
  logic [7:0]       score_nxt;
  logic [2:0]       lives_nxt;
  logic             offset_increase_nxt, edge_go_nxt, game_over_nxt;
  logic             tick, lose;

  assign current_state = {4'b0000, state};
  assign tick          = (div_cnt == period - 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      div_cnt         <= '0;
      period          <= TICK_DIV_V;
      row_cnt         <= '0;
      hit_flag        <= 1'b0;
      score           <= '0;
      lives           <= LIVES_V;
      offset_increase <= 1'b0;
      edge_go         <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      state           <= state_nxt;
      div_cnt         <= div_cnt_nxt;
      period          <= period_nxt;
      row_cnt         <= row_cnt_nxt;
      hit_flag        <= hit_flag_nxt;
      score           <= score_nxt;
      lives           <= lives_nxt;
      offset_increase <= offset_increase_nxt;
      edge_go         <= edge_go_nxt;
      game_over       <= game_over_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    div_cnt_nxt         = div_cnt;
    period_nxt          = period;
    row_cnt_nxt         = row_cnt;
    hit_flag_nxt        = hit_flag;
    score_nxt           = score;
    lives_nxt           = lives;
    offset_increase_nxt = 1'b0;
    edge_go_nxt         = 1'b0;
    lose                = 1'b0;

    case (state)
      IDLE: begin
        // Divider restarts from zero so every game's first tick lands at TICK_DIV.
        div_cnt_nxt = '0;
        if (start) begin
          score_nxt    = '0;
          lives_nxt    = LIVES_V;
          period_nxt   = TICK_DIV_V;
          row_cnt_nxt  = '0;
          hit_flag_nxt = 1'b0;
          state_nxt    = RUN;
        end
      end

      RUN, SHIFT: begin
        lose = key_miss;
        if (key_hit && !hit_flag) begin
          hit_flag_nxt = 1'b1;
          if (score != 8'hFF) score_nxt = score + 8'd1;
        end

        if (state == RUN) begin
          div_cnt_nxt = tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            if (offset >= EDGE_AT) begin
              edge_go_nxt = 1'b1;
              state_nxt   = SHIFT;
            end else begin
              offset_increase_nxt = 1'b1;
            end
          end
        end else begin
          // A key_hit arriving in this cycle still rescues the outgoing row.
          if (!hit_flag && !key_hit) lose = 1'b1;
          hit_flag_nxt = 1'b0;
          if (row_cnt + 1'b1 == SPEEDUP_V) begin
            row_cnt_nxt = '0;
            if (32'(period) >= MIN_DIV + DIV_STEP) period_nxt = period - DIV_STEP_V;
            else                                   period_nxt = MIN_DIV_V;
          end else begin
            row_cnt_nxt = row_cnt + 1'b1;
          end
          state_nxt = RUN;
        end

        if (lose && lives != 3'd0) lives_nxt = lives - 3'd1;
        if (lives_nxt == 3'd0) begin
          state_nxt           = OVER;
          offset_increase_nxt = 1'b0;
          edge_go_nxt         = 1'b0;
        end
      end

      OVER: begin
        if (start) state_nxt = IDLE;
      end
    endcase

    game_over_nxt = (state_nxt == OVER);
  end

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
// Directed bench for tile_scroll_ctrl: two configurations, each with an offset-counter
// model, walked cycle by cycle against hand-derived expectations.
module tb_tile_scroll_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       start_a, key_hit_a, key_miss_a;
  logic       start_b, key_hit_b, key_miss_b;
  logic [5:0] offset_a, offset_b;
  logic [5:0] state_a, state_b;
  logic       oi_a, oi_b, eg_a, eg_b, go_a, go_b;
  logic [7:0] score_a, score_b;
  logic [2:0] lives_a, lives_b;

  int compared   = 0;
  int mismatched = 0;

  tile_scroll_ctrl #(
    .TICK_DIV(4), .MIN_DIV(4), .DIV_STEP(1), .ROW_HEIGHT(3), .SPEEDUP_ROWS(8), .LIVES(2)
  ) u_a (
    .clock(clock), .reset(reset), .start(start_a), .offset(offset_a),
    .key_hit(key_hit_a), .key_miss(key_miss_a), .current_state(state_a),
    .offset_increase(oi_a), .edge_go(eg_a), .score(score_a), .lives(lives_a),
    .game_over(go_a)
  );

  tile_scroll_ctrl #(
    .TICK_DIV(8), .MIN_DIV(4), .DIV_STEP(3), .ROW_HEIGHT(3), .SPEEDUP_ROWS(1), .LIVES(3)
  ) u_b (
    .clock(clock), .reset(reset), .start(start_b), .offset(offset_b),
    .key_hit(key_hit_b), .key_miss(key_miss_b), .current_state(state_b),
    .offset_increase(oi_b), .edge_go(eg_b), .score(score_b), .lives(lives_b),
    .game_over(go_b)
  );

  // Offset counter models
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     offset_a <= '0;
    else if (eg_a) offset_a <= '0;
    else if (oi_a) offset_a <= offset_a + 6'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     offset_b <= '0;
    else if (eg_b) offset_b <= '0;
    else if (oi_b) offset_b <= offset_b + 6'd1;
  end

  task automatic do_reset();
    reset = 1'b1;
    {start_a, key_hit_a, key_miss_a, start_b, key_hit_b, key_miss_b} = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    compared += 6;
    if (state_a !== 6'd0) begin mismatched++; $display("FAIL rst_state: got %0d want 0", state_a); end
    if (score_a !== 8'd0) begin mismatched++; $display("FAIL rst_score: got %0d want 0", score_a); end
    if (lives_a !== 3'd2) begin mismatched++; $display("FAIL rst_lives_a: got %0d want 2", lives_a); end
    if (lives_b !== 3'd3) begin mismatched++; $display("FAIL rst_lives_b: got %0d want 3", lives_b); end
    if ({oi_a, eg_a, go_a} !== 3'b000) begin mismatched++; $display("FAIL rst_pulses: got %b want 000", {oi_a, eg_a, go_a}); end
    if ({oi_b, eg_b, go_b} !== 3'b000) begin mismatched++; $display("FAIL rst_pulses_b: got %b want 000", {oi_b, eg_b, go_b}); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_a = 1'b1;
    for (int k = 0; k <= 67; k++) begin
      @(negedge clock);
      {start_a, key_hit_a, key_miss_a} = '0;
      if (k == 67) begin
        compared += 3;
        if (score_a !== 8'd5) begin mismatched++; $display("FAIL pre_rst_score: got %0d want 5", score_a); end
        if (lives_a !== 3'd1) begin mismatched++; $display("FAIL pre_rst_lives: got %0d want 1", lives_a); end
        if (state_a !== 6'd1) begin mismatched++; $display("FAIL pre_rst_state: got %0d want 1", state_a); end
      end
      if (k % 13 == 1 && k <= 53) key_hit_a = 1'b1;
      if (k == 66) key_miss_a = 1'b1;
    end
    #2 reset = 1'b1;
    #1;
    compared += 5;
    if (state_a !== 6'd0) begin mismatched++; $display("FAIL async_state: got %0d want 0", state_a); end
    if (score_a !== 8'd0) begin mismatched++; $display("FAIL async_score: got %0d want 0", score_a); end
    if (lives_a !== 3'd2) begin mismatched++; $display("FAIL async_lives: got %0d want 2", lives_a); end
    if ({oi_a, eg_a} !== 2'b00) begin mismatched++; $display("FAIL async_pulses: got %b want 00", {oi_a, eg_a}); end
    if (go_a !== 1'b0) begin mismatched++; $display("FAIL async_game_over: got %b want 0", go_a); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_cadence();
    logic exp_oi, exp_eg;
    logic [5:0] exp_st;
    do_reset();
    start_a = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clock);
      start_a = 1'b0;
      exp_oi = (k == 4 || k == 8);
      exp_eg = (k == 12);
      exp_st = (k == 12) ? 6'd2 : 6'd1;
      compared += 3;
      if (oi_a !== exp_oi) begin mismatched++; $display("FAIL cad_oi k=%0d: got %b want %b", k, oi_a, exp_oi); end
      if (eg_a !== exp_eg) begin mismatched++; $display("FAIL cad_eg k=%0d: got %b want %b", k, eg_a, exp_eg); end
      if (state_a !== exp_st) begin mismatched++; $display("FAIL cad_state k=%0d: got %0d want %0d", k, state_a, exp_st); end
      if (k == 4 || k == 8 || k == 12 || k == 13) begin
        compared++;
        if (offset_a !== ((k == 13) ? 6'd0 : 6'(k / 4 - 1))) begin
          mismatched++; $display("FAIL cad_offset k=%0d: got %0d want %0d", k, offset_a, (k == 13) ? 0 : k / 4 - 1);
        end
      end
      if (k == 13) begin
        compared++;
        if (lives_a !== 3'd1) begin mismatched++; $display("FAIL cad_lives: got %0d want 1", lives_a); end
      end
    end
  endtask

  task automatic test_scoring();
    do_reset();
    start_a = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clock);
      {start_a, key_hit_a, key_miss_a} = '0;
      if (k == 4) begin
        compared++;
        if (score_a !== 8'd1) begin mismatched++; $display("FAIL dbl_hit_score: got %0d want 1", score_a); end
      end
      if (k == 13) begin
        compared += 2;
        if (score_a !== 8'd1) begin mismatched++; $display("FAIL shift_rehit_score: got %0d want 1", score_a); end
        if (lives_a !== 3'd2) begin mismatched++; $display("FAIL hit_row_lives: got %0d want 2", lives_a); end
      end
      if (k == 25) begin
        compared++;
        if (state_a !== 6'd2) begin mismatched++; $display("FAIL row2_shift_state: got %0d want 2", state_a); end
      end
      if (k == 26) begin
        compared += 3;
        if (score_a !== 8'd2) begin mismatched++; $display("FAIL shift_hit_score: got %0d want 2", score_a); end
        if (lives_a !== 3'd2) begin mismatched++; $display("FAIL shift_hit_lives: got %0d want 2", lives_a); end
        if (state_a !== 6'd1) begin mismatched++; $display("FAIL shift_hit_state: got %0d want 1", state_a); end
      end
      if (k == 1 || k == 2 || k == 12 || k == 25) key_hit_a = 1'b1;
    end
  endtask

  task automatic test_misses();
    do_reset();
    start_a = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clock);
      {start_a, key_hit_a, key_miss_a} = '0;
      if (k == 12) begin
        compared++;
        if (lives_a !== 3'd2) begin mismatched++; $display("FAIL miss1_pre_lives: got %0d want 2", lives_a); end
      end
      if (k == 13) begin
        compared++;
        if (lives_a !== 3'd1) begin mismatched++; $display("FAIL miss1_lives: got %0d want 1", lives_a); end
      end
      if (k == 25) begin
        compared++;
        if (go_a !== 1'b0) begin mismatched++; $display("FAIL miss2_early_over: got %b want 0", go_a); end
      end
      if (k == 26) begin
        compared += 3;
        if (lives_a !== 3'd0) begin mismatched++; $display("FAIL miss2_lives: got %0d want 0", lives_a); end
        if (state_a !== 6'd3) begin mismatched++; $display("FAIL miss2_state: got %0d want 3", state_a); end
        if (go_a !== 1'b1) begin mismatched++; $display("FAIL miss2_game_over: got %b want 1", go_a); end
      end
      if (k >= 28) begin
        compared += 3;
        if (score_a !== 8'd0) begin mismatched++; $display("FAIL over_score k=%0d: got %0d want 0", k, score_a); end
        if ({oi_a, eg_a} !== 2'b00) begin mismatched++; $display("FAIL over_pulses k=%0d: got %b want 00", k, {oi_a, eg_a}); end
        if (lives_a !== 3'd0) begin mismatched++; $display("FAIL over_lives k=%0d: got %0d want 0", k, lives_a); end
      end
      if (k == 27) key_hit_a = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_a = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clock);
      {start_a, key_hit_a, key_miss_a} = '0;
      if (k == 13) begin
        compared += 3;
        if (lives_a !== 3'd1) begin mismatched++; $display("FAIL simul_lives: got %0d want 1", lives_a); end
        if (state_a !== 6'd1) begin mismatched++; $display("FAIL simul_state: got %0d want 1", state_a); end
        if (go_a !== 1'b0) begin mismatched++; $display("FAIL simul_game_over: got %b want 0", go_a); end
      end
      if (k == 12) key_miss_a = 1'b1;
    end
  endtask

  task automatic test_speedup();
    int times[$];
    int exp_times[12] = '{8, 16, 24, 30, 35, 40, 45, 49, 53, 58, 62, 66};
    logic exp_oi;
    do_reset();
    start_b = 1'b1;
    for (int k = 0; k <= 86; k++) begin
      @(negedge clock);
      {start_b, key_hit_b, key_miss_b} = '0;
      if (k <= 67 && (oi_b || eg_b)) times.push_back(k);
      if (k == 73) begin
        compared += 4;
        if (state_b !== 6'd3) begin mismatched++; $display("FAIL spd_over_state: got %0d want 3", state_b); end
        if (lives_b !== 3'd0) begin mismatched++; $display("FAIL spd_over_lives: got %0d want 0", lives_b); end
        if (go_b !== 1'b1) begin mismatched++; $display("FAIL spd_game_over: got %b want 1", go_b); end
        if (score_b !== 8'd4) begin mismatched++; $display("FAIL spd_score: got %0d want 4", score_b); end
      end
      if (k == 76) begin
        compared += 3;
        if (state_b !== 6'd0) begin mismatched++; $display("FAIL to_idle_state: got %0d want 0", state_b); end
        if (score_b !== 8'd4) begin mismatched++; $display("FAIL idle_score: got %0d want 4", score_b); end
        if (go_b !== 1'b0) begin mismatched++; $display("FAIL idle_game_over: got %b want 0", go_b); end
      end
      if (k == 78) begin
        compared += 3;
        if (state_b !== 6'd1) begin mismatched++; $display("FAIL restart_state: got %0d want 1", state_b); end
        if (score_b !== 8'd0) begin mismatched++; $display("FAIL restart_score: got %0d want 0", score_b); end
        if (lives_b !== 3'd3) begin mismatched++; $display("FAIL restart_lives: got %0d want 3", lives_b); end
      end
      if (k >= 79) begin
        exp_oi = (k == 86);
        compared++;
        if (oi_b !== exp_oi) begin mismatched++; $display("FAIL restart_period k=%0d: got %b want %b", k, oi_b, exp_oi); end
      end
      if (k == 1 || k == 26 || k == 42 || k == 55) key_hit_b = 1'b1;
      if (k == 68 || k == 70 || k == 72) key_miss_b = 1'b1;
      if (k == 75 || k == 77) start_b = 1'b1;
    end
    compared++;
    if (times.size() != 12) begin
      mismatched++; $display("FAIL spd_pulse_count: got %0d want 12", times.size());
    end
    for (int i = 0; i < 12; i++) begin
      compared++;
      if (i >= times.size()) begin
        mismatched++; $display("FAIL spd_pulse_time[%0d]: got none want %0d", i, exp_times[i]);
      end else if (times[i] != exp_times[i]) begin
        mismatched++; $display("FAIL spd_pulse_time[%0d]: got %0d want %0d", i, times[i], exp_times[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {start_a, key_hit_a, key_miss_a, start_b, key_hit_b, key_miss_b} = '0;
    test_reset();
    test_cadence();
    test_scoring();
    test_misses();
    test_simultaneous();
    test_speedup();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
